// File: rtl/pll_cfg_pkg.sv
// Register map and divider presets for the system PLL reconfiguration writer.
// Optional PLL_CFG_FRAC_EN adds a 32-bit fractional K word to every preset.
package pll_cfg_pkg;

  localparam int unsigned NumClkMax = 3;

  localparam logic [5:0] AddrMode  = 6'd0;
  localparam logic [5:0] AddrStart = 6'd2;
  localparam logic [5:0] AddrN     = 6'd3;
  localparam logic [5:0] AddrM     = 6'd4;
  localparam logic [5:0] AddrC     = 6'd5;
  localparam logic [5:0] AddrK     = 6'd7;

  typedef enum logic {
    PresetSys = 1'b0,
    PresetAlt = 1'b1
  } preset_sel_e;

  // Bit layout matches the reconfig word: [17] odd, [16] bypass, [15:8] high, [7:0] low.
  typedef struct packed {
    logic       odd;
    logic       bypass;
    logic [7:0] high;
    logic [7:0] low;
  } div_word_t;

  typedef struct packed {
`ifdef PLL_CFG_FRAC_EN
    logic [31:0]                 k;
`endif
    div_word_t                   n;
    div_word_t                   m;
    div_word_t [NumClkMax-1:0]   c;
  } preset_t;

  function automatic preset_t preset_lookup(input preset_sel_e sel);
    preset_t p;
    p = '0;
    if (sel == PresetSys) begin
      // 50 MHz ref: N=5, M=84, C=70/60/35 -> 12/14/24 MHz
      p.n    = 18'h20302;
      p.m    = 18'h02A2A;
      p.c[0] = 18'h02323;
      p.c[1] = 18'h01E1E;
      p.c[2] = 18'h21211;
`ifdef PLL_CFG_FRAC_EN
      p.k    = 32'h4000_0000;
`endif
    end else begin
      p.n    = 18'h10000;
      p.m    = 18'h01010;
      p.c[0] = 18'h00808;
      p.c[1] = 18'h20504;
      p.c[2] = 18'h10000;
`ifdef PLL_CFG_FRAC_EN
      p.k    = 32'h0123_4567;
`endif
    end
    return p;
  endfunction

endpackage

// File: rtl/pll_cfg_writer.sv
// Avalon-MM writer that loads a PLL divider preset, starts reconfig and supervises relock.
// Define PLL_CFG_FRAC_EN to insert the fractional K write between M and the C counters.
module pll_cfg_writer
  import pll_cfg_pkg::*;
#(
  parameter int unsigned NUM_CLK      = 3,
  parameter int unsigned LOCK_HOLDOFF = 64,
  parameter int unsigned LOCK_TIMEOUT = 50000
) (
  input  logic        i_refclk,
  input  logic        i_rst,
  input  logic        i_cfg_req,
  input  logic        i_cfg_sel,
  input  logic        i_locked,
  output logic [5:0]  o_mgmt_address,
  output logic        o_mgmt_write,
  output logic [31:0] o_mgmt_writedata,
  input  logic        i_mgmt_waitrequest,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned HoldW = (LOCK_HOLDOFF > 1) ? $clog2(LOCK_HOLDOFF) : 1;
  localparam int unsigned TmoW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int unsigned CidxW = (NumClkMax > 1) ? $clog2(NumClkMax) : 1;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StWrMode   = 4'd1;
  localparam logic [3:0] StWrN      = 4'd2;
  localparam logic [3:0] StWrM      = 4'd3;
  localparam logic [3:0] StWrC      = 4'd4;
  localparam logic [3:0] StWrStart  = 4'd5;
  localparam logic [3:0] StHoldoff  = 4'd6;
  localparam logic [3:0] StWaitLock = 4'd7;
  localparam logic [3:0] StFin      = 4'd8;
`ifdef PLL_CFG_FRAC_EN
  localparam logic [3:0] StWrK      = 4'd9;
`endif

  logic [3:0]       r_state, w_state_nxt;
  preset_sel_e      r_sel, w_sel_nxt;
  logic [CidxW-1:0] r_cidx, w_cidx_nxt;
  logic [HoldW-1:0] r_hcnt, w_hcnt_nxt;
  logic [TmoW-1:0]  r_tcnt, w_tcnt_nxt;
  logic             r_lock_s1, r_lock_s2;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             w_ack;
  preset_t          w_preset;

  assign w_ack    = o_mgmt_write & ~i_mgmt_waitrequest;
  assign w_preset = preset_lookup(r_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cidx_nxt  = r_cidx;
    w_hcnt_nxt  = r_hcnt;
    w_tcnt_nxt  = r_tcnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cfg_req) begin
          w_state_nxt = StWrMode;
          w_sel_nxt   = preset_sel_e'(i_cfg_sel);
        end
      end
      StWrMode: if (w_ack) w_state_nxt = StWrN;
      StWrN:    if (w_ack) w_state_nxt = StWrM;
      StWrM: begin
        if (w_ack) begin
`ifdef PLL_CFG_FRAC_EN
          w_state_nxt = StWrK;
`else
          w_state_nxt = StWrC;
`endif
          w_cidx_nxt  = '0;
        end
      end
`ifdef PLL_CFG_FRAC_EN
      StWrK: if (w_ack) w_state_nxt = StWrC;
`endif
      StWrC: begin
        if (w_ack) begin
          if (r_cidx == CidxW'(NUM_CLK - 1)) begin
            w_state_nxt = StWrStart;
            w_cidx_nxt  = '0;
          end else begin
            w_cidx_nxt  = r_cidx + 1'b1;
          end
        end
      end
      StWrStart: begin
        if (w_ack) begin
          w_state_nxt = StHoldoff;
          w_hcnt_nxt  = '0;
        end
      end
      StHoldoff: begin
        if (r_hcnt == HoldW'(LOCK_HOLDOFF - 1)) begin
          w_state_nxt = StWaitLock;
          w_tcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt  = r_hcnt + 1'b1;
        end
      end
      StWaitLock: begin
        // Lock wins over a timeout landing on the same cycle, keeping done/err exclusive.
        if (r_lock_s2) begin
          w_state_nxt = StFin;
          w_done_nxt  = 1'b1;
        end else if (r_tcnt == TmoW'(LOCK_TIMEOUT - 1)) begin
          w_state_nxt = StFin;
          w_err_nxt   = 1'b1;
        end else if (r_tcnt != '1) begin
          w_tcnt_nxt  = r_tcnt + 1'b1;
        end
      end
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_sel     <= PresetSys;
      r_cidx    <= '0;
      r_hcnt    <= '0;
      r_tcnt    <= '0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_cidx    <= w_cidx_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_lock_s1 <= i_locked;
      r_lock_s2 <= r_lock_s1;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Bus outputs decode straight from registered state so reset drops the strobe at once.
  always_comb begin
    o_mgmt_write     = 1'b0;
    o_mgmt_address   = AddrMode;
    o_mgmt_writedata = '0;
    unique case (r_state)
      StWrMode: o_mgmt_write = 1'b1;
      StWrN: begin
        o_mgmt_write     = 1'b1;
        o_mgmt_address   = AddrN;
        o_mgmt_writedata = {14'd0, w_preset.n};
      end
      StWrM: begin
        o_mgmt_write     = 1'b1;
        o_mgmt_address   = AddrM;
        o_mgmt_writedata = {14'd0, w_preset.m};
      end
`ifdef PLL_CFG_FRAC_EN
      StWrK: begin
        o_mgmt_write     = 1'b1;
        o_mgmt_address   = AddrK;
        o_mgmt_writedata = w_preset.k;
      end
`endif
      StWrC: begin
        o_mgmt_write     = 1'b1;
        o_mgmt_address   = AddrC;
        o_mgmt_writedata = {9'd0, 5'(r_cidx), w_preset.c[r_cidx]};
      end
      StWrStart: begin
        o_mgmt_write     = 1'b1;
        o_mgmt_address   = AddrStart;
      end
      default: ;
    endcase
  end

  assign o_busy = (r_state != StIdle) && (r_state != StFin);
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Directed self-checking bench for pll_cfg_writer; honours PLL_CFG_FRAC_EN for the K write.
module tb_pll_cfg_writer;

  localparam int unsigned Holdoff = 64;
  localparam int unsigned Timeout = 50000;
`ifdef PLL_CFG_FRAC_EN
  localparam int unsigned NumWr = 8;
`else
  localparam int unsigned NumWr = 7;
`endif

  logic        clk;
  logic        rst;
  logic        cfg_req;
  logic        cfg_sel;
  logic        locked;
  logic [5:0]  addr;
  logic        write;
  logic [31:0] wdata;
  logic        waitreq;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [5:0]  mon_addr_q[$];
  logic [31:0] mon_data_q[$];
  int          wr_cycles = 0;
  int          done_cnt  = 0;
  int          err_cnt   = 0;
  int          both_cnt  = 0;

  pll_cfg_writer #(
    .NUM_CLK     (3),
    .LOCK_HOLDOFF(Holdoff),
    .LOCK_TIMEOUT(Timeout)
  ) dut (
    .i_refclk          (clk),
    .i_rst             (rst),
    .i_cfg_req         (cfg_req),
    .i_cfg_sel         (cfg_sel),
    .i_locked          (locked),
    .o_mgmt_address    (addr),
    .o_mgmt_write      (write),
    .o_mgmt_writedata  (wdata),
    .i_mgmt_waitrequest(waitreq),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change 1 ns after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    if (write) begin
      wr_cycles <= wr_cycles + 1;
      if (!waitreq) begin
        mon_addr_q.push_back(addr);
        mon_data_q.push_back(wdata);
      end
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic sel);
    cfg_sel = sel;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
  endtask

  task automatic wait_for_write(input logic [5:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (write && addr == a) found = 1'b1;
    end
    check({tag, " reached"}, 32'(found), 32'd1);
  endtask

  task automatic wait_done_or_err(input int budget, input string tag, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      cycles++;
      if (done || err) seen = 1'b1;
    end
    check({tag, " completion"}, 32'(seen), 32'd1);
  endtask

  // Hand-derived write streams; C data carries the counter index in [22:18].
  task automatic verify_writes(input int base, input logic sel, input string tag);
    logic [5:0]  ea[$];
    logic [31:0] ed[$];
    ea.push_back(6'd0); ed.push_back(32'h0);
    ea.push_back(6'd3); ed.push_back(sel ? 32'h10000 : 32'h20302);
    ea.push_back(6'd4); ed.push_back(sel ? 32'h01010 : 32'h02A2A);
`ifdef PLL_CFG_FRAC_EN
    ea.push_back(6'd7); ed.push_back(sel ? 32'h0123_4567 : 32'h4000_0000);
`endif
    ea.push_back(6'd5); ed.push_back(sel ? 32'h00808 : 32'h02323);
    ea.push_back(6'd5); ed.push_back(sel ? 32'h60504 : 32'h41E1E);
    ea.push_back(6'd5); ed.push_back(sel ? 32'h90000 : 32'hA1211);
    ea.push_back(6'd2); ed.push_back(32'h0);
    check({tag, " write count"}, 32'(mon_addr_q.size() - base), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++) begin
      if (base + i < mon_addr_q.size()) begin
        check($sformatf("%s wr%0d addr", tag, i), 32'(mon_addr_q[base+i]), 32'(ea[i]));
        check($sformatf("%s wr%0d data", tag, i), mon_data_q[base+i], ed[i]);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, e0, c0, n;
    rst = 1'b1; cfg_req = 1'b0; cfg_sel = 1'b0; locked = 1'b0; waitreq = 1'b0;
    tick();
    tick();
    check("reset write", 32'(write), 32'd0);
    check("reset addr", 32'(addr), 32'd0);
    check("reset data", wdata, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Preset 0, no stalls, lock 100 cycles after START.
    base = mon_addr_q.size(); d0 = done_cnt; e0 = err_cnt; c0 = wr_cycles;
    request(1'b0);
    check("t1 first write latency", 32'(write), 32'd1);
    check("t1 busy on accept", 32'(busy), 32'd1);
    wait_for_write(6'd2, "t1 start");
    tick();
    repeat (100) tick();
    locked = 1'b1;
    wait_done_or_err(20, "t1", n);
    check("t1 lock-to-done cycles", 32'(n), 32'd3);
    check("t1 done level", 32'(done), 32'd1);
    check("t1 busy in fin", 32'(busy), 32'd0);
    locked = 1'b0;
    repeat (4) tick();
    verify_writes(base, 1'b0, "t1");
    check("t1 write cycles", 32'(wr_cycles - c0), 32'(NumWr));
    check("t1 done pulses", 32'(done_cnt - d0), 32'd1);
    check("t1 err pulses", 32'(err_cnt - e0), 32'd0);

    // No lock: err exactly holdoff + timeout edges after START acceptance.
    d0 = done_cnt; e0 = err_cnt;
    request(1'b0);
    wait_for_write(6'd2, "t3 start");
    tick();
    wait_done_or_err(Timeout + Holdoff + 100, "t3", n);
    check("t3 err latency", 32'(n), 32'(Holdoff + Timeout));
    check("t3 err level", 32'(err), 32'd1);
    check("t3 done level", 32'(done), 32'd0);
    check("t3 busy in fin", 32'(busy), 32'd0);
    repeat (4) tick();
    check("t3 err pulses", 32'(err_cnt - e0), 32'd1);
    check("t3 done pulses", 32'(done_cnt - d0), 32'd0);

    // Preset 1 with a 3-cycle stall on the M write.
    locked = 1'b1;
    base = mon_addr_q.size(); d0 = done_cnt; c0 = wr_cycles;
    request(1'b1);
    wait_for_write(6'd4, "t2 m");
    waitreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2 stall%0d write", i), 32'(write), 32'd1);
      check($sformatf("t2 stall%0d addr", i), 32'(addr), 32'd4);
      check($sformatf("t2 stall%0d data", i), wdata, 32'h01010);
    end
    waitreq = 1'b0;
    wait_done_or_err(300, "t2", n);
    repeat (4) tick();
    verify_writes(base, 1'b1, "t2");
    check("t2 write cycles", 32'(wr_cycles - c0), 32'(NumWr + 3));
    check("t2 done pulses", 32'(done_cnt - d0), 32'd1);

    // Requests during WR_C and during FIN are dropped.
    base = mon_addr_q.size(); d0 = done_cnt;
    request(1'b0);
    wait_for_write(6'd5, "t4 c");
    cfg_sel = 1'b1;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    wait_done_or_err(300, "t4", n);
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    repeat (20) tick();
    check("t4 busy after", 32'(busy), 32'd0);
    verify_writes(base, 1'b0, "t4");
    check("t4 done pulses", 32'(done_cnt - d0), 32'd1);

    // Async reset during a stalled C write, then a clean rerun.
    d0 = done_cnt; e0 = err_cnt;
    request(1'b0);
    wait_for_write(6'd5, "t5 c");
    waitreq = 1'b1;
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5 rst write", 32'(write), 32'd0);
    check("t5 rst addr", 32'(addr), 32'd0);
    check("t5 rst data", wdata, 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst done", 32'(done), 32'd0);
    check("t5 rst err", 32'(err), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    waitreq = 1'b0;
    repeat (100) tick();
    check("t5 no pulse done", 32'(done_cnt - d0), 32'd0);
    check("t5 no pulse err", 32'(err_cnt - e0), 32'd0);
    base = mon_addr_q.size(); d0 = done_cnt;
    request(1'b1);
    wait_done_or_err(300, "t5", n);
    repeat (4) tick();
    verify_writes(base, 1'b1, "t5");
    check("t5 done pulses", 32'(done_cnt - d0), 32'd1);
    check("done err overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
